hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_AW, default 5: register-index width.
REQ-002 SHALL provide parameter LOAD_LAT, default 1, legal 1..4: total stall cycles per load-use hazard.
REQ-003 SHALL provide parameter FLUSH_CYC, default 1, legal 1..3: total flush cycles per taken jump/branch.
REQ-004 SHALL provide parameter CNT_W, default 16: width of the event counters.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL provide clk  in  1  rising-edge clock.
REQ-007 SHALL provide rst_n  in  1  synchronous active-low reset.
REQ-008 SHALL provide jump  in  1  jump in ID is resolved taken.
REQ-009 SHALL provide branch  in  1  branch in ID is resolved taken.
REQ-010 SHALL provide mem2reg  in  1  instruction in ID is a load.
REQ-011 SHALL provide id_rt  in  REG_AW  destination register of the ID load.
REQ-012 SHALL provide if_rs, if_rt  in  REG_AW each  source registers of the IF instruction.
REQ-013 SHALL provide if_use_rs, if_use_rt  in  1 each  IF instruction actually reads rs / rt.
REQ-014 SHALL provide stall  out  1  hold PC and IF/ID.
REQ-015 SHALL provide bubble  out  1  insert NOP into ID/EX.
REQ-016 SHALL provide flush  out  1  kill IF/ID contents.
REQ-017 SHALL provide hazard  out  1  stall OR flush, for single-signal pipelines.
REQ-018 SHALL provide stall_events, flush_events  out  CNT_W each  saturating event counters.
REQ-019 SHALL provide busy  out  1  FSM not in IDLE.

Function
REQ-020 SHALL compute luse = mem2reg & (id_rt!=0) & ((if_use_rs & id_rt==if_rs) | (if_use_rt & id_rt==if_rt)).
REQ-021 SHALL compute ctl = jump | branch.
REQ-022 SHALL implement FSM states IDLE, STALL, FLUSH with a down-counter cnt (2 bits minimum) and a latched register pend_rd.
REQ-023 In IDLE with ctl=1 SHALL assert flush in the same cycle (combinational); if FLUSH_CYC>1, next state FLUSH with cnt=FLUSH_CYC-1; otherwise stay IDLE.
REQ-024 In IDLE with ctl=0 and luse=1 SHALL assert stall and bubble in the same cycle; if LOAD_LAT>1, next state STALL with cnt=LOAD_LAT-1 and pend_rd=id_rt; otherwise stay IDLE.
REQ-025 ctl SHALL take priority over luse when both are 1 in IDLE: flush only, no stall, no bubble.
REQ-026 In STALL SHALL assert stall and bubble; decrement cnt each cycle; return to IDLE in the cycle after the one in which cnt==1.
REQ-027 In FLUSH SHALL assert flush only; decrement cnt each cycle; return to IDLE in the cycle after the one in which cnt==1.
REQ-028 ctl=1 while in STALL SHALL abort the stall: stall/bubble deassert that cycle, flush asserts, and the FSM follows the IDLE ctl rule (REQ-023).
REQ-029 ctl=1 while in FLUSH SHALL restart the flush: flush asserts and cnt reloads to FLUSH_CYC-1 (next state IDLE if FLUSH_CYC==1).
REQ-030 luse in STALL or FLUSH SHALL be ignored; it does not extend the stall.
REQ-031 hazard SHALL equal stall|flush in every cycle; busy SHALL equal (state!=IDLE).
REQ-032 stall_events SHALL increment once per stall episode (on IDLE entry into stall), flush_events once per cycle in which ctl=1 causes a flush; both saturate at 2^CNT_W-1.
REQ-033 With LOAD_LAT=1 and FLUSH_CYC=1, hazard SHALL equal the single-cycle rule: (mem2reg & id_rt!=0 & rt match on rs or rt) | jump | branch, with both use flags tied high.

Reset
REQ-034 While rst_n=0 at a rising edge SHALL set state=IDLE, cnt=0, pend_rd=0, stall_events=0, flush_events=0.
REQ-035 While rst_n=0, stall, bubble, flush, hazard and busy SHALL be 0 regardless of inputs.
REQ-036 Reset asserted mid-STALL or mid-FLUSH SHALL abort the episode with no residual output after release.

Verification
REQ-037 LOAD_LAT=3: mem2reg=1, id_rt=8, if_rs=8, if_use_rs=1 for one cycle -> stall=bubble=1 for exactly 3 cycles, busy=1 for cycles 2-3, stall_events=1.
REQ-038 id_rt=0 with if_rs=0 and mem2reg=1 -> no stall; if_use_rt=0 with id_rt==if_rt -> no stall.
REQ-039 FLUSH_CYC=2: branch=1 and luse=1 in the same cycle -> flush=1 for 2 cycles, stall=0, flush_events=1.
REQ-040 LOAD_LAT=4: jump=1 in the 2nd stall cycle -> stall drops that cycle, flush=1, FSM ends in IDLE (FLUSH_CYC=1).
REQ-041 CNT_W=2: 5 single-cycle jumps -> flush_events holds at 3.
REQ-042 rst_n=0 in the 2nd cycle of a LOAD_LAT=4 stall -> all outputs 0 in the next cycle and after release with idle inputs.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Pipeline hazard unit for a classic IF/ID/EX pipeline. It detects load-use
//   hazards between a load sitting in ID and the instruction being fetched in
//   IF, and taken jumps/branches resolved in ID. A load-use hazard stalls the
//   front end for LOAD_LAT cycles. A taken control transfer flushes IF/ID for
//   FLUSH_CYC cycles. Saturating counters record how many stall episodes and
//   flush-causing control events have occurred.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   jump          in   jump in ID resolved taken
//   branch        in   branch in ID resolved taken
//   mem2reg       in   instruction in ID is a load
//   id_rt         in   destination register of the ID load
//   if_rs, if_rt  in   source registers of the IF instruction
//   if_use_rs/rt  in   IF instruction actually reads rs / rt
//   stall         out  hold PC and IF/ID
//   bubble        out  insert NOP into ID/EX
//   flush         out  kill IF/ID contents
//   hazard        out  stall | flush
//   stall_events  out  saturating count of stall episodes
//   flush_events  out  saturating count of flush-causing ctl cycles
//   busy          out  multi-cycle episode in progress (FSM not idle)
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump,
    input  logic              branch,
    input  logic              mem2reg,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] if_rs,
    input  logic [REG_AW-1:0] if_rt,
    input  logic              if_use_rs,
    input  logic              if_use_rt,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic              hazard,
    output logic [CNT_W-1:0]  stall_events,
    output logic [CNT_W-1:0]  flush_events,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // The first hazard cycle is signalled combinationally from IDLE, so the
    // FSM only has to cover the remaining LAT-1 cycles.
    localparam logic [1:0]       LOAD_RELOAD  = 2'(LOAD_LAT - 1);
    localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0]  stall_events_q, flush_events_q;

    logic luse;
    logic ctl;
    logic stall_c;
    logic flush_c;
    logic stall_inc;
    logic flush_inc;

    // Register 0 is hard-wired zero, so a load targeting it never creates a
    // dependency.
    assign luse = mem2reg && (id_rt != '0) &&
                  ((if_use_rs && (id_rt == if_rs)) ||
                   (if_use_rt && (id_rt == if_rt)));
    assign ctl  = jump | branch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rd_d = pend_rd_q;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (ctl) begin
            // A taken control transfer wins in every state: it starts a new
            // flush from IDLE, aborts a stall, or restarts a running flush.
            flush_c   = 1'b1;
            flush_inc = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_d = S_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (luse) begin
                        stall_c   = 1'b1;
                        stall_inc = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d   = S_STALL;
                            cnt_d     = LOAD_RELOAD;
                            pend_rd_d = id_rt;
                        end
                    end
                end
                S_STALL: begin
                    // luse is ignored here; a stall never self-extends.
                    stall_c = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                S_FLUSH: begin
                    flush_c = 1'b1;
                    if (cnt_q == 2'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 2'd0;
            pend_rd_q      <= '0;
            stall_events_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_rd_q <= pend_rd_d;
            if (stall_inc && (stall_events_q != CNT_MAX)) begin
                stall_events_q <= stall_events_q + CNT_ONE;
            end
            if (flush_inc && (flush_events_q != CNT_MAX)) begin
                flush_events_q <= flush_events_q + CNT_ONE;
            end
        end
    end

    // Outputs are gated by rst_n so nothing leaks out while reset is held,
    // even before the first reset edge has cleared the state register.
    assign stall        = rst_n & stall_c;
    assign bubble       = rst_n & stall_c;
    assign flush        = rst_n & flush_c;
    assign hazard       = rst_n & (stall_c | flush_c);
    assign busy         = rst_n & (state_q != S_IDLE);
    assign stall_events = stall_events_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Three differently parameterised scoreboards share one stimulus stream:
//   u_a : LOAD_LAT=3, FLUSH_CYC=2, CNT_W=16
//   u_b : LOAD_LAT=4, FLUSH_CYC=1, CNT_W=2
//   u_c : LOAD_LAT=1, FLUSH_CYC=1, CNT_W=4
// A reference model tracks "cycles of stall/flush still owed" per instance
// and the event counts, and every output is compared once per cycle.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       jump, branch, mem2reg;
    logic [4:0] id_rt, if_rs, if_rt;
    logic       if_use_rs, if_use_rt;

    logic [2:0]  st_w, bb_w, fl_w, hz_w, bz_w;
    logic [15:0] sev_a, fev_a;
    logic [1:0]  sev_b, fev_b;
    logic [3:0]  sev_c, fev_c;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one slot per instance.
    int lat_p[3]  = '{3, 4, 1};
    int fcyc_p[3] = '{2, 1, 1};
    int cmax_p[3] = '{65535, 3, 15};
    int stall_owed[3];
    int flush_owed[3];
    int sev_m[3];
    int fev_m[3];

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .jump(jump), .branch(branch), .mem2reg(mem2reg),
        .id_rt(id_rt), .if_rs(if_rs), .if_rt(if_rt),
        .if_use_rs(if_use_rs), .if_use_rt(if_use_rt),
        .stall(st_w[0]), .bubble(bb_w[0]), .flush(fl_w[0]), .hazard(hz_w[0]),
        .stall_events(sev_a), .flush_events(fev_a), .busy(bz_w[0])
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(4), .FLUSH_CYC(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .jump(jump), .branch(branch), .mem2reg(mem2reg),
        .id_rt(id_rt), .if_rs(if_rs), .if_rt(if_rt),
        .if_use_rs(if_use_rs), .if_use_rt(if_use_rt),
        .stall(st_w[1]), .bubble(bb_w[1]), .flush(fl_w[1]), .hazard(hz_w[1]),
        .stall_events(sev_b), .flush_events(fev_b), .busy(bz_w[1])
    );

    hazard_scoreboard #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .jump(jump), .branch(branch), .mem2reg(mem2reg),
        .id_rt(id_rt), .if_rs(if_rs), .if_rt(if_rt),
        .if_use_rs(if_use_rs), .if_use_rt(if_use_rt),
        .stall(st_w[2]), .bubble(bb_w[2]), .flush(fl_w[2]), .hazard(hz_w[2]),
        .stall_events(sev_c), .flush_events(fev_c), .busy(bz_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sev_of(input int i);
        case (i)
            0:       return int'(sev_a);
            1:       return int'(sev_b);
            default: return int'(sev_c);
        endcase
    endfunction

    function automatic int fev_of(input int i);
        case (i)
            0:       return int'(fev_a);
            1:       return int'(fev_b);
            default: return int'(fev_c);
        endcase
    endfunction

    // One clock cycle: apply inputs just after the rising edge, compare on the
    // falling edge, advance the model, then move to just past the next edge.
    task automatic drive(input logic rn, input logic j, input logic b, input logic m,
                         input logic [4:0] drt, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt);
        bit use_hit, ctl_now;
        bit e_stall, e_flush, e_busy;
        int n_stall, n_flush, n_sev, n_fev;
        rst_n = rn; jump = j; branch = b; mem2reg = m;
        id_rt = drt; if_rs = rs; if_rt = rt; if_use_rs = urs; if_use_rt = urt;
        use_hit = m && (drt != 0) && ((urs && drt == rs) || (urt && drt == rt));
        ctl_now = j || b;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e_stall = 0; e_flush = 0;
            e_busy  = rn && (stall_owed[i] > 0 || flush_owed[i] > 0);
            n_stall = stall_owed[i]; n_flush = flush_owed[i];
            n_sev   = sev_m[i];      n_fev   = fev_m[i];
            if (!rn) begin
                n_stall = 0; n_flush = 0; n_sev = 0; n_fev = 0;
            end else if (ctl_now) begin
                e_flush = 1;
                n_flush = fcyc_p[i] - 1;
                n_stall = 0;
                if (n_fev < cmax_p[i]) n_fev++;
            end else if (flush_owed[i] > 0) begin
                e_flush = 1;
                n_flush--;
            end else if (stall_owed[i] > 0) begin
                e_stall = 1;
                n_stall--;
            end else if (use_hit) begin
                e_stall = 1;
                n_stall = lat_p[i] - 1;
                if (n_sev < cmax_p[i]) n_sev++;
            end
            check_eq($sformatf("stall[%0d]", i),  st_w[i], e_stall);
            check_eq($sformatf("bubble[%0d]", i), bb_w[i], e_stall);
            check_eq($sformatf("flush[%0d]", i),  fl_w[i], e_flush);
            check_eq($sformatf("hazard[%0d]", i), hz_w[i], e_stall | e_flush);
            check_eq($sformatf("busy[%0d]", i),   bz_w[i], e_busy);
            check_eq($sformatf("stall_events[%0d]", i), sev_of(i), sev_m[i]);
            check_eq($sformatf("flush_events[%0d]", i), fev_of(i), fev_m[i]);
            stall_owed[i] = n_stall; flush_owed[i] = n_flush;
            sev_m[i] = n_sev; fev_m[i] = n_fev;
        end
        // Single-cycle configuration must collapse to the plain hazard rule.
        if (urs && urt) begin
            check_eq("single_cycle_rule", hz_w[2],
                     rn && ((m && drt != 0 && (drt == rs || drt == rt)) || j || b));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_cycle();
        // Busy-looking inputs while in reset: outputs must still be zero.
        drive(0, 1, 1, 1, 8, 8, 8, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            stall_owed[i] = 0; flush_owed[i] = 0; sev_m[i] = 0; fev_m[i] = 0;
        end
        rst_n = 0; jump = 0; branch = 0; mem2reg = 0;
        id_rt = 0; if_rs = 0; if_rt = 0; if_use_rs = 0; if_use_rt = 0;
        @(posedge clk);
        #1;
        reset_cycle();
        idle_cycles(2);

        // Load-use on rs for one cycle.
        reset_cycle();
        drive(1, 0, 0, 1, 8, 8, 0, 1, 0);
        idle_cycles(5);
        check_eq("load_use_sev_a", sev_a, 1);
        $display("scenario load_use_rs done");

        // r0 never creates a dependency; an unused rt never stalls.
        reset_cycle();
        drive(1, 0, 0, 1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 1, 5, 3, 5, 1, 0);
        idle_cycles(2);
        check_eq("no_dep_sev_a", sev_a, 0);
        $display("scenario no_dependency done");

        // Branch and load-use together: flush wins.
        reset_cycle();
        drive(1, 0, 1, 1, 8, 8, 0, 1, 0);
        idle_cycles(3);
        check_eq("ctl_prio_fev_a", fev_a, 1);
        check_eq("ctl_prio_sev_a", sev_a, 0);
        $display("scenario ctl_priority done");

        // Jump in the 2nd stall cycle aborts the stall.
        reset_cycle();
        drive(1, 0, 0, 1, 9, 0, 9, 0, 1);
        drive(1, 1, 0, 1, 9, 0, 9, 0, 1);
        idle_cycles(4);
        $display("scenario stall_abort done");

        // Five jumps saturate the 2-bit counter.
        reset_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            idle_cycles(1);
        end
        check_eq("sat_fev_b", fev_b, 3);
        $display("scenario counter_saturation done");

        // Reset in the middle of a long stall.
        reset_cycle();
        drive(1, 0, 0, 1, 7, 7, 7, 1, 1);
        drive(0, 0, 0, 1, 7, 7, 7, 1, 1);
        idle_cycles(5);
        $display("scenario reset_mid_stall done");

        // Randomised traffic with a narrow register range to provoke hazards.
        for (int k = 0; k < 2000; k++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        $display("scenario random_traffic done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
